// File: rtl/vga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pkg: shared screen geometry, default widths and blitter states.
// Revision: 1.0
// ------------------------------------------------------------------
package vga_pkg;

  localparam int         VGA_SCREEN_X    = 160;
  localparam int         VGA_SCREEN_Y    = 120;
  localparam int         VGA_WIDTH_X     = 8;
  localparam int         VGA_WIDTH_Y     = 7;
  localparam logic [2:0] VGA_TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/blit_scanner.sv
`default_nettype none
// ------------------------------------------------------------------
// blit_scanner: raster-order sprite read counter with last-pixel flag.
// Revision: 1.0
// ------------------------------------------------------------------
module blit_scanner
  import vga_pkg::*;
#(
  parameter int WIDTH_X = VGA_WIDTH_X,
  parameter int WIDTH_Y = VGA_WIDTH_Y
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               advance,
  input  logic [WIDTH_X-1:0] spr_w,
  input  logic [WIDTH_Y-1:0] spr_h,
  output logic [WIDTH_X-1:0] src_x,
  output logic [WIDTH_Y-1:0] src_y,
  output logic               last
);

  logic [WIDTH_X-1:0] r_w;
  logic [WIDTH_Y-1:0] r_h;
  logic               w_end_x;
  logic               w_end_y;

  assign w_end_x = (src_x == r_w - WIDTH_X'(1));
  assign w_end_y = (src_y == r_h - WIDTH_Y'(1));
  assign last    = w_end_x && w_end_y;

  // Size is captured with the clear so the wrap points stay fixed for the blit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_w   <= '0;
      r_h   <= '0;
      src_x <= '0;
      src_y <= '0;
    end else if (clear) begin
      r_w   <= spr_w;
      r_h   <= spr_h;
      src_x <= '0;
      src_y <= '0;
    end else if (advance && !last) begin
      if (w_end_x) begin
        src_x <= '0;
        src_y <= src_y + WIDTH_Y'(1);
      end else begin
        src_x <= src_x + WIDTH_X'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_blitter: copies a sprite from RAM to a clipped VGA pixel-write port.
// Revision: 1.0
// ------------------------------------------------------------------
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int         WIDTH_X     = VGA_WIDTH_X,
  parameter int         WIDTH_Y     = VGA_WIDTH_Y,
  parameter int         SCREEN_X    = VGA_SCREEN_X,
  parameter int         SCREEN_Y    = VGA_SCREEN_Y,
  parameter logic [2:0] TRANSPARENT = VGA_TRANSPARENT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH_X-1:0] origin_x,
  input  logic [WIDTH_Y-1:0] origin_y,
  input  logic [WIDTH_X-1:0] spr_w,
  input  logic [WIDTH_Y-1:0] spr_h,
  output logic [WIDTH_X-1:0] src_x,
  output logic [WIDTH_Y-1:0] src_y,
  input  logic [2:0]         src_color,
  output logic [WIDTH_X-1:0] vga_x,
  output logic [WIDTH_Y-1:0] vga_y,
  output logic [2:0]         vga_color,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH_X:0] c_screen_x = (WIDTH_X + 1)'(SCREEN_X);
  localparam logic [WIDTH_Y:0] c_screen_y = (WIDTH_Y + 1)'(SCREEN_Y);

  blit_state_t        r_state;
  blit_state_t        w_next;
  logic               r_drain;
  logic               w_accept;
  logic               w_nonzero;
  logic               w_last;
  logic [WIDTH_X-1:0] r_org_x;
  logic [WIDTH_Y-1:0] r_org_y;
  logic               r_p1_valid;
  logic [WIDTH_X-1:0] r_p1_x;
  logic [WIDTH_Y-1:0] r_p1_y;
  logic [WIDTH_X:0]   w_sum_x;
  logic [WIDTH_Y:0]   w_sum_y;

  assign w_nonzero = (spr_w != '0) && (spr_h != '0);

  blit_scanner #(
    .WIDTH_X (WIDTH_X),
    .WIDTH_Y (WIDTH_Y)
  ) u_scanner (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_accept && w_nonzero),
    .advance (r_state == SCAN),
    .spr_w   (spr_w),
    .spr_h   (spr_h),
    .src_x   (src_x),
    .src_y   (src_y),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // FINISH also accepts start so blits can run back to back.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_nonzero ? SCAN : FINISH;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain) w_next = FINISH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_nonzero ? SCAN : FINISH;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sum_x = {1'b0, r_org_x} + {1'b0, r_p1_x};
  assign w_sum_y = {1'b0, r_org_y} + {1'b0, r_p1_y};

  // Stage 1 aligns coordinates with the one-cycle RAM latency; stage 2 is the write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drain    <= 1'b0;
      r_org_x    <= '0;
      r_org_y    <= '0;
      r_p1_valid <= 1'b0;
      r_p1_x     <= '0;
      r_p1_y     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_color  <= '0;
      vga_plot   <= 1'b0;
    end else begin
      r_drain <= (r_state == DRAIN) && !r_drain;
      if (w_accept) begin
        r_org_x <= origin_x;
        r_org_y <= origin_y;
      end
      r_p1_valid <= (r_state == SCAN);
      r_p1_x     <= src_x;
      r_p1_y     <= src_y;
      vga_x      <= w_sum_x[WIDTH_X-1:0];
      vga_y      <= w_sum_y[WIDTH_Y-1:0];
      vga_color  <= src_color;
      vga_plot   <= r_p1_valid && (w_sum_x < c_screen_x) && (w_sum_y < c_screen_y)
                    && (src_color != TRANSPARENT);
    end
  end

endmodule
`default_nettype wire

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter WIDTH_X, default 8, screen/sprite x coordinate width.
REQ-002 Parameter WIDTH_Y, default 7, screen/sprite y coordinate width.
REQ-003 Parameter SCREEN_X, default 160, visible columns.
REQ-004 Parameter SCREEN_Y, default 120, visible rows.
REQ-005 Parameter TRANSPARENT, default 3'b000, color value never plotted.
REQ-006 clk  input  1  single clock, all state on its rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request a blit; sampled only when busy=0.
REQ-009 origin_x / origin_y  input  WIDTH_X / WIDTH_Y  screen position of sprite top-left pixel.
REQ-010 spr_w / spr_h  input  WIDTH_X / WIDTH_Y  sprite width/height in pixels.
REQ-011 src_x / src_y  output  WIDTH_X / WIDTH_Y  registered sprite-RAM read coordinate.
REQ-012 src_color  input  3  sprite-RAM data, valid one cycle after src_x/src_y.
REQ-013 vga_x / vga_y / vga_color  output  WIDTH_X / WIDTH_Y / 3  registered pixel write to VGA adapter.
REQ-014 vga_plot  output  1  write enable for vga_x/vga_y/vga_color.
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle pulse at blit completion.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN, FINISH; IDLE->SCAN on start with spr_w!=0 and spr_h!=0; IDLE->FINISH on start with zero size.
REQ-018 origin and size SHALL be latched on start acceptance; later input changes have no effect on that blit.
REQ-019 Start accepted at edge 0: busy=1 from cycle 1; src=(0,0) in cycle 1; pixel index k (raster order, x fastest) presented on src in cycle 1+k.
REQ-020 SCAN: src_x increments to spr_w-1, then wraps to 0 with src_y+1; SCAN->DRAIN after src=(spr_w-1,spr_h-1).
REQ-021 DRAIN lasts exactly 2 cycles, then FINISH; FINISH lasts 1 cycle with done=1 and busy=0, then IDLE.
REQ-022 Pixel k SHALL appear on vga_x/vga_y/vga_color in cycle 3+k; vga_x=origin_x+src_x, vga_y=origin_y+src_y, sums computed at WIDTH+1 bits.
REQ-023 vga_plot=1 only when pixel valid, sum_x<SCREEN_X, sum_y<SCREEN_Y, and src_color!=TRANSPARENT; else 0 (coordinate/color values don't-care).
REQ-024 Total: done in cycle spr_w*spr_h+3 for nonzero size; cycle 1 for zero size with no vga_plot.
REQ-025 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be accepted (back-to-back blits).
REQ-026 vga_plot SHALL be 0 in IDLE, FINISH, and DRAIN after the last pixel leaves the pipe.

Reset
REQ-027 resetn low SHALL immediately force IDLE, busy=0, done=0, vga_plot=0, src/vga coordinates and color to 0, clearing the pipeline.
REQ-028 Reset mid-blit SHALL abandon the blit with no further vga_plot and no done pulse.

Structure
REQ-029 Package vga_pkg SHALL hold SCREEN_X, SCREEN_Y, default widths, TRANSPARENT, and the state enum.
REQ-030 Raster counter (src_x/src_y, wrap, last-pixel flag) SHALL be a sub-module blit_scanner; pipeline and clip logic stay in sprite_blitter.

Verification
REQ-031 origin (10,20), 2x2, RAM colors 1,2,3,4 -> vga_plot cycles 3-6 at (10,20)c1,(11,20)c2,(10,21)c3,(11,21)c4; done cycle 7.
REQ-032 Same, RAM pixel 1 = 3'b000 -> plot at (11,20) suppressed, other three plotted, done still cycle 7.
REQ-033 origin (159,119), 2x2, all opaque -> only (159,119) plotted; done cycle 7.
REQ-034 spr_w=0, spr_h=5 -> no vga_plot, done cycle 1, busy never high.
REQ-035 3x3 blit, resetn low in cycle 4 -> all outputs 0 same cycle, no further plot, no done; new start after release behaves per REQ-019.
REQ-036 start pulsed in cycle 2 of a 2x2 blit -> ignored; start in done cycle -> second blit begins, src=(0,0) next cycle.
